// File: rtl/ws2812_transmitter.sv
// WS2812 NRZ line driver: pulls LED_COUNT*3 bytes from the fader per frame and
// shifts them out MSB-first, then holds the line low for the latch period.
module ws2812_transmitter #(
  parameter int LED_COUNT = 8,
  parameter int T0H       = 4,
  parameter int T1H       = 8,
  parameter int T_BIT     = 15,
  parameter int T_RESET   = 3600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic [7:0] color_now,
  output logic       data_request,
  output logic       dout,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] fsm_state   // debug: 0 IDLE, 1 REQ, 2 CAPTURE, 3 SEND, 4 LATCH
);

  localparam int NUM_BYTES = LED_COUNT * 3;
  localparam int BW        = $clog2(NUM_BYTES + 1);
  localparam int CMAX      = (T_BIT > T_RESET) ? T_BIT : T_RESET;
  localparam int CW        = $clog2(CMAX);

  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(T_BIT - 1);
  localparam logic [CW-1:0] LATCH_END = CW'(T_RESET - 1);
  localparam logic [CW-1:0] HI0       = CW'(T0H);
  localparam logic [CW-1:0] HI1       = CW'(T1H);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    LATCH   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          dout_d, req_d, busy_d, done_d;
  logic          last_bit, last_byte;

  assign last_bit  = (bit_q == 3'd7);
  assign last_byte = (byte_q == LAST_BYTE);
  assign fsm_state = state_q;

  // Byte handshake: a one-cycle data_request pulse means color_now must carry
  // the next byte in the following cycle; there is no back-pressure.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: if (trigger) state_d = REQ;
      REQ:  state_d = CAPTURE;
      CAPTURE: begin
        shift_d = color_now;
        bit_d   = '0;
        byte_d  = '0;
        cyc_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        // Prefetched byte arrives one cycle after the request in the last bit.
        if (cyc_q == CW'(1) && last_bit && !last_byte) hold_d = color_now;
        if (cyc_q == BIT_END) begin
          cyc_d = '0;
          if (last_bit) begin
            bit_d = '0;
            if (last_byte) begin
              state_d = LATCH;
            end else begin
              byte_d  = byte_q + BW'(1);
              shift_d = hold_q;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      LATCH: begin
        if (cyc_q == LATCH_END) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the upcoming state.
    dout_d = (state_d == SEND) && (cyc_d < (shift_d[7] ? HI1 : HI0));
    req_d  = (state_d == REQ) ||
             ((state_d == SEND) && (cyc_d == '0) && (bit_d == 3'd7) && (byte_d != LAST_BYTE));
    busy_d = (state_d != IDLE);
    done_d = (state_d == LATCH) && (cyc_d == LATCH_END);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      dout         <= 1'b0;
      data_request <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      dout         <= dout_d;
      data_request <= req_d;
      busy         <= busy_d;
      frame_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_ws2812_transmitter.sv
// Bench for ws2812_transmitter: a fader-like byte source feeds expected pulse
// widths to a scoreboard; a monitor measures the line and frame timing.
`timescale 1ns/1ps
module tb_ws2812_transmitter;

  localparam int LED_COUNT = 1;
  localparam int T0H       = 2;
  localparam int T1H       = 4;
  localparam int T_BIT     = 6;
  localparam int T_RESET   = 10;
  localparam int NUM_BYTES = LED_COUNT * 3;
  localparam int BUSY_LEN  = 2 + 24 * LED_COUNT * T_BIT + T_RESET;
  localparam int GAP_FIRST = 2 + 7 * T_BIT;
  localparam int GAP_NEXT  = 8 * T_BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trigger = 1'b0;
  logic [7:0] color_now = 8'h00;
  logic       data_request, dout, busy, frame_done;
  logic [2:0] fsm_state;

  ws2812_transmitter #(
    .LED_COUNT(LED_COUNT), .T0H(T0H), .T1H(T1H), .T_BIT(T_BIT), .T_RESET(T_RESET)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .color_now(color_now),
    .data_request(data_request), .dout(dout), .busy(busy),
    .frame_done(frame_done), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  bit         noisy = 1'b0;
  bit         tie = 1'b0;
  int         frame_count = 0;
  int         req_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: each byte goes out MSB first; a 1 is a long pulse, a 0 short.
  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--)
      exp_q.push_back(((b >> i) & 8'd1) != 0 ? 8'(T1H) : 8'(T0H));
  endtask

  // Byte source: presents a byte in the cycle after each request.
  logic       prev_req = 1'b0;
  logic [7:0] src_byte;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      prev_req  = 1'b0;
      color_now = 8'($urandom);
    end else begin
      if (prev_req) begin
        src_byte  = (src_q.size() != 0) ? src_q.pop_front() : 8'($urandom);
        color_now = src_byte;
        push_byte(src_byte);
      end else if (noisy) begin
        color_now = 8'($urandom);
      end
      prev_req = data_request;
    end
  end

  // Monitor
  int         cyc = 0, busy_start = 0, last_rise = 0, last_req = 0;
  int         hi_run = 0, low_run = 0, idle_run = 0;
  int         rises = 0, reqs = 0, dones = 0, tie_frames = 0;
  logic       prev_dout = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
  logic [7:0] exp_w;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("reset_outputs", int'({dout, data_request, busy, frame_done}), 0);
      check("reset_state", int'(fsm_state), 0);
      exp_q.delete();
      hi_run = 0; rises = 0; reqs = 0; dones = 0; idle_run = 0;
      prev_dout = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
    end else begin
      if (!tie) tie_frames = 0;
      if (busy && !prev_busy) begin
        busy_start = cyc; rises = 0; reqs = 0; dones = 0; low_run = 0;
        if (tie && tie_frames > 0) check("idle_gap", idle_run, 1);
        idle_run = 0;
      end
      if (!busy) idle_run++;
      if (dout) begin
        check("dout_inside_frame", int'(busy), 1);
        if (!prev_dout) begin
          if (rises == 0) check("first_rise", cyc - busy_start, 2);
          else check("bit_period", cyc - last_rise, T_BIT);
          rises++;
          last_rise = cyc;
        end
        hi_run++;
        low_run = 0;
      end else begin
        if (hi_run > 0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", hi_run, 0);
          end else begin
            exp_w = exp_q.pop_front();
            check("pulse_width", hi_run, int'(exp_w));
          end
          hi_run = 0;
        end
        if (busy) low_run++;
      end
      if (data_request) begin
        check("req_inside_frame", int'(busy), 1);
        if (reqs == 0) check("first_req_offset", cyc - busy_start, 0);
        else check("req_spacing", cyc - last_req, (reqs == 1) ? GAP_FIRST : GAP_NEXT);
        reqs++;
        req_total++;
        last_req = cyc;
      end
      if (frame_done) dones++;
      if (!busy && prev_busy) begin
        check("busy_length", cyc - busy_start, BUSY_LEN);
        check("requests_per_frame", reqs, NUM_BYTES);
        check("frame_done_count", dones, 1);
        check("frame_done_last_cycle", int'(prev_done), 1);
        check("latch_low_cycles", int'(low_run >= T_RESET), 1);
        check("bits_outstanding", exp_q.size(), 0);
        frame_count++;
        if (tie) tie_frames++;
      end
      prev_dout = dout;
      prev_busy = busy;
      prev_done = frame_done;
    end
  end

  // Driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit noise_trig);
    int target;
    target  = frame_count + 1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < BUSY_LEN + 20 && frame_count < target; i++) begin
      tick();
      trigger = (noise_trig && busy && !frame_done) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    trigger = 1'b0;
    check("frame_completed", frame_count, target);
    repeat (20) tick();
    check("no_extra_frame", frame_count, target);
    check("idle_after_frame", int'(busy), 0);
  endtask

  initial begin
    int r0, f0, fds, target;
    #2 rst = 1'b0;
    repeat (8) begin
      tick();
      trigger = 1'($urandom_range(0, 1));
    end
    trigger = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // Known bytes, steady source
    src_q.push_back(8'hA5); src_q.push_back(8'h00); src_q.push_back(8'hFF);
    run_frame(1'b0);

    // Same bytes with stray triggers during SEND and LATCH
    src_q.push_back(8'hA5); src_q.push_back(8'h00); src_q.push_back(8'hFF);
    run_frame(1'b1);

    // Random bytes, source garbage outside the valid cycle
    noisy = 1'b1;
    repeat (4) begin
      for (int i = 0; i < NUM_BYTES; i++) src_q.push_back(8'($urandom));
      run_frame(1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the second byte
    for (int i = 0; i < NUM_BYTES; i++) src_q.push_back(8'($urandom));
    r0 = req_total;
    f0 = frame_count;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 200 && req_total < r0 + 2; i++) tick();
    check("second_request_seen", req_total, r0 + 2);
    repeat (3 * T_BIT + 1) tick();
    rst = 1'b0;
    #1;
    check("dout_async_reset", int'(dout), 0);
    check("busy_async_reset", int'(busy), 0);
    r0 = req_total;
    repeat (5) tick();
    rst = 1'b1;
    repeat (20) tick();
    check("no_req_after_reset", req_total, r0);
    check("no_resume_after_reset", frame_count, f0);
    src_q.delete();
    for (int i = 0; i < NUM_BYTES; i++) src_q.push_back(8'($urandom));
    run_frame(1'b0);

    // Trigger tied high for three frames
    tie = 1'b1;
    target = frame_count + 3;
    fds = 0;
    trigger = 1'b1;
    for (int i = 0; i < 4 * BUSY_LEN && fds < 3; i++) begin
      tick();
      if (frame_done) fds++;
    end
    trigger = 1'b0;
    for (int i = 0; i < 20 && frame_count < target; i++) tick();
    repeat (20) tick();
    tie = 1'b0;
    check("tied_frames", frame_count, target);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, frames %0d", frame_count);
    $fatal(1);
  end

endmodule
